// File: rtl/freq_meter_if.sv
// Signal bundle for the period/high-time meter.
// The master drives the enable and the waveform being measured and reads back
// the results. The slave is the meter itself.
interface freq_meter_if #(
  parameter int CNT_W = 27
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             stalled_o;

  modport master (
    output en,
    output sig_in,
    input  period_o,
    input  high_o,
    input  valid_o,
    input  stalled_o
  );

  modport slave (
    input  en,
    input  sig_in,
    output period_o,
    output high_o,
    output valid_o,
    output stalled_o
  );
endinterface

// File: rtl/freq_meter.sv
// Period and high-time meter for a slow free-running square wave.
// sig_in is synchronised into the clk domain. The block counts clk cycles
// between rising edges, and from a rising edge to the following falling edge.
// Each completed period is reported with a one-cycle valid pulse. If no rising
// edge arrives within TIMEOUT cycles, the input is flagged as stalled and the
// meter falls back to waiting for a fresh reference edge.
module freq_meter #(
  parameter int CNT_W   = 27,
  parameter int TIMEOUT = 100000000
) (
  input logic         clk,
  input logic         rst_p,
  freq_meter_if.slave bus
);

  // Timeout threshold at counter width. TIMEOUT must lie in [2, 2^CNT_W).
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_t;

  // Counter step that stops at the timeout value. Within a period the counter
  // therefore never wraps, even if the timeout compare were missed.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c >= TMO) r = TMO;
    else          r = c + CNT_W'(1);
    return r;
  endfunction

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_sh;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_r;
  logic             valid_r;
  logic             stalled_r;
  logic             rise;
  logic             fall;

  // Edge detect on the synchronised copy. prev is only the one-cycle-old value.
  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  // Synchroniser, period counter, high-time shadow, state and registered results.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      cnt       <= '0;
      hi_sh     <= '0;
      period_r  <= '0;
      high_r    <= '0;
      valid_r   <= 1'b0;
      stalled_r <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      // The synchroniser keeps running while en is low. A level already high
      // when en returns is then not mistaken for a fresh edge.
      sync1   <= bus.sig_in;
      sync2   <= sync1;
      prev    <= sync2;
      valid_r <= 1'b0;

      if (!bus.en) begin
        // Disabled: drop any partial measurement and keep the last results.
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            // The first rise only starts a period. It has nothing to report.
            if (rise) begin
              state <= ST_MEASURE;
              cnt   <= CNT_W'(1);
            end else begin
              cnt <= '0;
            end
          end

          ST_MEASURE: begin
            // The falling edge captures the high time of the current period.
            if (fall) hi_sh <= cnt;

            if (rise) begin
              // A rise takes priority over a coincident timeout. A period of
              // exactly TIMEOUT cycles is therefore still reported.
              period_r  <= cnt;
              high_r    <= hi_sh;
              valid_r   <= 1'b1;
              stalled_r <= 1'b0;
              cnt       <= CNT_W'(1);
            end else if (cnt == TMO) begin
              // Input has stopped toggling. Keep the last results and re-arm.
              state     <= ST_IDLE;
              stalled_r <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc(cnt);
            end
          end

          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period_o  = period_r;
  assign bus.high_o    = high_r;
  assign bus.valid_o   = valid_r;
  assign bus.stalled_o = stalled_r;

endmodule
